// File: rtl/prbs_tx_gen.sv
// prbs_tx_gen -- PRBS9 (x^9 + x^5 + 1) transmit bit source for the BER link test.
//
// One symbol is emitted every OS_FACTOR clocks. o_bit is registered and
// stable from one clock before o_valid through the o_valid clock; o_valid is
// a one-clock strobe. A rising edge of i_enable restarts the sequence from
// i_seed (an all-zero seed is replaced by 9'h001 so the LFSR cannot lock up).
//
// Handshake: o_valid/o_bit form a push-only stream with no back-pressure.
// o_bit, o_sof and o_sym_idx are meaningful only in a clock where o_valid is
// high. The consumer must take the symbol in that clock; nothing is held or
// replayed.
//
// Optional build macro PRBS_ERR_INJECT_EN: when defined, i_err_inject high
// inverts o_bit for the symbol with index ERR_POS in every 511-symbol frame,
// without touching the LFSR. When undefined, i_err_inject is a pin-compatible
// input that is ignored.
module prbs_tx_gen #(
    parameter int PRBS_LEN  = 9,
    parameter int OS_FACTOR = 4,
    parameter int ERR_POS   = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [PRBS_LEN-1:0] i_seed,
    input  logic                i_err_inject,
    output logic                o_valid,
    output logic                o_bit,
    output logic                o_sof,
    output logic [PRBS_LEN-1:0] o_sym_idx
);

    // Width of the oversampling counter; at least one bit.
    localparam int OS_W = (OS_FACTOR > 1) ? $clog2(OS_FACTOR) : 1;

    // Last count of a symbol period: o_valid is raised from this count.
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_FACTOR - 1);

    // Count at which o_bit is loaded, one clock ahead of the strobe.
    localparam logic [OS_W-1:0] OS_CAP = OS_W'(OS_FACTOR - 2);

    // Highest symbol index in a frame (period 2^PRBS_LEN - 1 = 511).
    localparam logic [PRBS_LEN-1:0] SYM_LAST = PRBS_LEN'((1 << PRBS_LEN) - 2);

    // Symbol index that error insertion corrupts.
    localparam logic [PRBS_LEN-1:0] ERR_IDX = PRBS_LEN'(ERR_POS);

    // Lock-up free reload value used when i_seed is zero.
    localparam logic [PRBS_LEN-1:0] SEED_GUARD = PRBS_LEN'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  enable_q;
    logic                  enable_rise;
    logic                  run_active;
    logic                  sym_end;
    logic                  bit_load;
    logic                  err_flip;
    logic                  feedback;

    logic [PRBS_LEN-1:0]   seed_guarded;
    logic [PRBS_LEN-1:0]   lfsr;
    logic [PRBS_LEN-1:0]   sym_idx;
    logic [OS_W-1:0]       os_cnt;

    logic                  valid_r;
    logic                  bit_r;
    logic                  sof_r;

    // A restart only happens on a fresh low-to-high transition of i_enable.
    assign enable_rise = i_enable & ~enable_q;

    // RUN is kept only while i_enable stays high; dropping it idles next clock.
    assign run_active = (state == RUN) && i_enable;

    // Final clock of a symbol period.
    assign sym_end = (os_cnt == OS_LAST);

    // Clock in which the upcoming symbol's bit is registered.
    assign bit_load = (os_cnt == OS_CAP);

    // Zero seed would stall the LFSR forever; substitute a single 1.
    assign seed_guarded = (i_seed == '0) ? SEED_GUARD : i_seed;

    // Fibonacci feedback for x^9 + x^5 + 1: s[n+9] = s[n] ^ s[n+4].
    assign feedback = lfsr[PRBS_LEN-1] ^ lfsr[4];

`ifdef PRBS_ERR_INJECT_EN
    // sym_idx already names the upcoming symbol when its bit is loaded.
    assign err_flip = i_err_inject && (sym_idx == ERR_IDX);
`else
    // Pin kept for compatibility; its value never reaches the stream.
    logic unused_err_inject;
    assign unused_err_inject = i_err_inject;
    assign err_flip          = 1'b0;
`endif

    // Previous i_enable, used for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= i_enable;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: IDLE waits for an enable rising edge, RUN ends on enable low.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (enable_rise) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Oversampling counter: cleared on restart, wraps every OS_FACTOR clocks in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_cnt <= '0;
        end else if ((state == IDLE) && enable_rise) begin
            os_cnt <= '0;
        end else if (run_active) begin
            os_cnt <= sym_end ? '0 : os_cnt + 1'b1;
        end
    end

    // LFSR: loaded from the guarded seed on restart, advanced on each strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_GUARD;
        end else if ((state == IDLE) && enable_rise) begin
            lfsr <= seed_guarded;
        end else if (run_active && valid_r) begin
            lfsr <= {lfsr[PRBS_LEN-2:0], feedback};
        end
    end

    // Symbol index: cleared on restart, stepped after each strobe, wraps 510 -> 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_idx <= '0;
        end else if ((state == IDLE) && enable_rise) begin
            sym_idx <= '0;
        end else if (run_active && valid_r) begin
            sym_idx <= (sym_idx == SYM_LAST) ? '0 : sym_idx + 1'b1;
        end
    end

    // Registered stream outputs; all forced low whenever not actively running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            bit_r   <= 1'b0;
            sof_r   <= 1'b0;
        end else if (!run_active) begin
            valid_r <= 1'b0;
            bit_r   <= 1'b0;
            sof_r   <= 1'b0;
        end else begin
            valid_r <= sym_end;
            sof_r   <= sym_end && (sym_idx == '0);
            if (bit_load) begin
                bit_r <= lfsr[PRBS_LEN-1] ^ err_flip;
            end
        end
    end

    assign o_valid   = valid_r;
    assign o_bit     = bit_r;
    assign o_sof     = sof_r;
    assign o_sym_idx = sym_idx;

endmodule

// File: tb/tb_prbs_tx_gen.sv
// tb_prbs_tx_gen -- directed-sequence bench for prbs_tx_gen with a
// recurrence-based reference stream and an expected-symbol queue.
module tb_prbs_tx_gen;

  localparam int PRBS_LEN  = 9;
  localparam int OS_FACTOR = 4;
  localparam int ERR_POS   = 100;
  localparam int PERIOD    = 511;

`ifdef PRBS_ERR_INJECT_EN
  localparam bit INJ_BUILT = 1'b1;
`else
  localparam bit INJ_BUILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                i_enable = 1'b0;
  logic [PRBS_LEN-1:0] i_seed = '0;
  logic                i_err_inject = 1'b0;
  logic                o_valid;
  logic                o_bit;
  logic                o_sof;
  logic [PRBS_LEN-1:0] o_sym_idx;

  always #5 clk = ~clk;

  prbs_tx_gen #(
    .PRBS_LEN  (PRBS_LEN),
    .OS_FACTOR (OS_FACTOR),
    .ERR_POS   (ERR_POS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_seed       (i_seed),
    .i_err_inject (i_err_inject),
    .o_valid      (o_valid),
    .o_bit        (o_bit),
    .o_sof        (o_sof),
    .o_sym_idx    (o_sym_idx)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic        gold[0:PERIOD-1];
  logic [10:0] exp_q[$];          // {sof, sym_idx[8:0], bit}
  logic        obs_bits[0:2047];
  int          obs_n = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference stream: first 9 bits are the seed MSB first, then s[n+9] = s[n] ^ s[n+4].
  function automatic void build_gold(input logic [PRBS_LEN-1:0] seed);
    logic [PRBS_LEN-1:0] s;
    s = (seed == '0) ? 9'h001 : seed;
    for (int i = 0; i < 9; i++) gold[i] = s[8-i];
    for (int i = 9; i < PERIOD; i++) gold[i] = gold[i-9] ^ gold[i-5];
  endfunction

  function automatic void expect_syms(input int n, input logic inj);
    int   idx;
    logic b;
    for (int k = 0; k < n; k++) begin
      idx = k % PERIOD;
      b   = gold[idx];
      if (INJ_BUILT && inj && (idx == ERR_POS)) b = ~b;
      exp_q.push_back({(idx == 0), 9'(idx), b});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk n symbol periods: strobe must be low for OS_FACTOR-1 clocks then high for one.
  task automatic run_syms(input int n, input string tag);
    logic [10:0] e;
    for (int j = 0; j < n; j++) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s.queue observed=empty expected=entry", tag);
        return;
      end
      e = exp_q[0];
      for (int c = 0; c < OS_FACTOR - 1; c++) begin
        step();
        check({tag, ".gap_valid"}, 32'(o_valid), 32'd0);
      end
      check({tag, ".bit_early"}, 32'(o_bit), 32'(e[0]));
      step();
      check({tag, ".valid"}, 32'(o_valid), 32'd1);
      e = exp_q.pop_front();
      check({tag, ".bit"}, 32'(o_bit), 32'(e[0]));
      check({tag, ".sof"}, 32'(o_sof), 32'(e[10]));
      check({tag, ".idx"}, 32'(o_sym_idx), 32'(e[9:1]));
      if (obs_n < 2048) begin
        obs_bits[obs_n] = o_bit;
        obs_n++;
      end
    end
  endtask

  // One-clock enable low pulse, then a rising edge that samples seed.
  task automatic restart(input logic [PRBS_LEN-1:0] seed, input string tag);
    i_enable = 1'b0;
    step();
    check({tag, ".drop_valid"}, 32'(o_valid), 32'd0);
    check({tag, ".drop_bit"}, 32'(o_bit), 32'd0);
    check({tag, ".drop_sof"}, 32'(o_sof), 32'd0);
    i_seed   = seed;
    i_enable = 1'b1;
    step();
    exp_q.delete();
    obs_n = 0;
    build_gold(seed);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [14:0]         head15;
    logic [8:0]          head9;
    int                  ones;
    logic [PRBS_LEN-1:0] seed_a;
    logic [PRBS_LEN-1:0] seed_b;
    logic [PRBS_LEN-1:0] seed_c;
    logic [PRBS_LEN-1:0] seed_d;

    // 1. reset and idle
    repeat (3) step();
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.idx", 32'(o_sym_idx), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle.valid", 32'(o_valid), 32'd0);
      check("idle.bit", 32'(o_bit), 32'd0);
      check("idle.sof", 32'(o_sof), 32'd0);
      check("idle.idx", 32'(o_sym_idx), 32'd0);
    end

    // 2./3. seed 1FF, two full frames
    i_seed   = 9'h1FF;
    i_enable = 1'b1;
    step();
    build_gold(9'h1FF);
    exp_q.delete();
    obs_n = 0;
    expect_syms(2 * PERIOD, 1'b0);
    run_syms(2 * PERIOD, "seed1ff");
    for (int i = 0; i < 15; i++) head15[14-i] = obs_bits[i];
    check("seed1ff.head15", 32'(head15), 32'(15'b111111111000001));
    for (int f = 0; f < 2; f++) begin
      ones = 0;
      for (int i = 0; i < PERIOD; i++) ones += int'(obs_bits[f*PERIOD + i]);
      check("seed1ff.ones_per_frame", 32'(ones), 32'd256);
    end

    // 4. zero-seed guard
    restart(9'h000, "zero");
    expect_syms(20, 1'b0);
    run_syms(20, "zero");
    for (int i = 0; i < 9; i++) head9[8-i] = obs_bits[i];
    check("zero.head9", 32'(head9), 32'(9'b000000001));

    // 5a. mid-frame enable drop at sym_idx 300, seed changes after rise ignored
    seed_a = 9'($urandom_range(1, 511));
    restart(seed_a, "seeda");
    i_seed = 9'($urandom);
    expect_syms(300, 1'b0);
    run_syms(300, "seeda");
    step();
    seed_b = 9'($urandom_range(0, 511));
    restart(seed_b, "seedb");
    i_seed = 9'($urandom);
    expect_syms(51, 1'b0);
    run_syms(51, "seedb");

    // 5b. asynchronous reset while symbol 50 is being strobed
    #1 rst = 1'b0;
    #1;
    check("async_rst.valid", 32'(o_valid), 32'd0);
    check("async_rst.bit", 32'(o_bit), 32'd0);
    check("async_rst.sof", 32'(o_sof), 32'd0);
    check("async_rst.idx", 32'(o_sym_idx), 32'd0);
    seed_c = 9'($urandom_range(1, 511));
    i_seed = seed_c;
    #2 rst = 1'b1;
    step();
    exp_q.delete();
    build_gold(seed_c);
    expect_syms(10, 1'b0);
    run_syms(10, "after_rst");

    // 6. error insertion across two frames
    seed_d       = 9'($urandom_range(1, 511));
    i_err_inject = 1'b1;
    restart(seed_d, "inject");
    expect_syms(2 * PERIOD, 1'b1);
    run_syms(2 * PERIOD, "inject");
    i_err_inject = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
